// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the memory-side blocks.
package lc3b_types;

  localparam int unsigned LC3B_LINE_W = 128;

  typedef logic [LC3B_LINE_W-1:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D
  } arb_state_t;

endpackage

// File: rtl/pmem_arb_streak.sv
// Saturating count of consecutive D grants taken while an I request waits.
module pmem_arb_streak #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic at_max
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 4'd1;
    end
  end

  assign at_max = (count == 4'(MAX));

endmodule

// File: rtl/pmem_arbiter.sv
// Shares the physical-memory port between I-cache and D-cache; D wins ties
// unless the streak counter says the I-side has waited long enough.
module pmem_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned LINE_W       = 128,
  parameter int unsigned OFFSET_BITS  = 4,
  parameter int unsigned D_STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pmem_read,
  input  logic [15:0]       i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [15:0]       d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [15:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              arb_busy,
  output logic              arb_owner_d
);

  localparam logic [15:0] ADDR_MASK = ~16'((1 << OFFSET_BITS) - 1);

  arb_state_t state;
  logic       d_req;
  logic       grant_d;
  logic       grant_i;
  logic       at_max;
  logic       streak_clear;
  logic       streak_inc;

  assign d_req = d_pmem_read | d_pmem_write;

  always_comb begin
    grant_d      = 1'b0;
    grant_i      = 1'b0;
    streak_clear = 1'b0;
    streak_inc   = 1'b0;
    if (state == ARB_IDLE) begin
      grant_d      = d_req && (!i_pmem_read || !at_max);
      grant_i      = i_pmem_read && !grant_d;
      streak_inc   = grant_d && i_pmem_read;
      streak_clear = grant_i || !i_pmem_read;
    end
  end

  pmem_arb_streak #(
    .MAX(D_STREAK_MAX)
  ) u_streak (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (streak_clear),
    .inc   (streak_inc),
    .at_max(at_max)
  );

  // Strobes, address and data are captured at grant so that the caches may
  // change or drop their inputs mid-transaction without disturbing pmem.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARB_IDLE;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      arb_owner_d  <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_d) begin
            state        <= ARB_SERVE_D;
            arb_owner_d  <= 1'b1;
            pmem_write   <= d_pmem_write;
            pmem_read    <= d_pmem_read & ~d_pmem_write;
            pmem_address <= d_pmem_address & ADDR_MASK;
            pmem_wdata   <= d_pmem_wdata;
          end else if (grant_i) begin
            state        <= ARB_SERVE_I;
            arb_owner_d  <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
            pmem_address <= i_pmem_address & ADDR_MASK;
            pmem_wdata   <= '0;
          end
        end
        ARB_SERVE_I, ARB_SERVE_D: begin
          if (pmem_resp) begin
            state        <= ARB_IDLE;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign arb_busy = (state != ARB_IDLE);

  // A completion is only forwarded if the owner is still asking for it.
  always_comb begin
    i_pmem_resp  = 1'b0;
    i_pmem_rdata = '0;
    d_pmem_resp  = 1'b0;
    d_pmem_rdata = '0;
    if (pmem_resp) begin
      if (state == ARB_SERVE_I && i_pmem_read) begin
        i_pmem_resp  = 1'b1;
        i_pmem_rdata = pmem_rdata;
      end
      if (state == ARB_SERVE_D && d_req) begin
        d_pmem_resp  = 1'b1;
        d_pmem_rdata = pmem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: expected completions are queued as pmem
// responses are issued and checked by an independent resp monitor.
module tb_pmem_arbiter;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_pmem_read;
  logic [15:0] i_pmem_address;
  lc3b_line    i_pmem_rdata;
  logic        i_pmem_resp;
  logic        d_pmem_read;
  logic        d_pmem_write;
  logic [15:0] d_pmem_address;
  lc3b_line    d_pmem_wdata;
  lc3b_line    d_pmem_rdata;
  logic        d_pmem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  lc3b_line    pmem_wdata;
  lc3b_line    pmem_rdata;
  logic        pmem_resp;
  logic        arb_busy;
  logic        arb_owner_d;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic     side_d;
    lc3b_line data;
  } exp_t;

  exp_t sb[$];

  pmem_arbiter #(
    .LINE_W      (128),
    .OFFSET_BITS (4),
    .D_STREAK_MAX(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_pmem_read   (i_pmem_read),
    .i_pmem_address(i_pmem_address),
    .i_pmem_rdata  (i_pmem_rdata),
    .i_pmem_resp   (i_pmem_resp),
    .d_pmem_read   (d_pmem_read),
    .d_pmem_write  (d_pmem_write),
    .d_pmem_address(d_pmem_address),
    .d_pmem_wdata  (d_pmem_wdata),
    .d_pmem_rdata  (d_pmem_rdata),
    .d_pmem_resp   (d_pmem_resp),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp),
    .arb_busy      (arb_busy),
    .arb_owner_d   (arb_owner_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every forwarded completion must match the oldest queued one.
  always @(negedge clk) begin
    if (i_pmem_resp || d_pmem_resp) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected resp: i=%0b d=%0b with nothing queued", i_pmem_resp, d_pmem_resp);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp side d", d_pmem_resp, e.side_d);
        chk("resp side i", i_pmem_resp, !e.side_d);
        if (e.side_d) begin
          chk("d rdata", d_pmem_rdata, e.data);
          chk("i rdata idle", i_pmem_rdata, '0);
        end else begin
          chk("i rdata", i_pmem_rdata, e.data);
          chk("d rdata idle", d_pmem_rdata, '0);
        end
      end
    end
  end

  task automatic wait_grant(input string name, input logic exp_d, input logic [15:0] addr,
                            input logic rd, input logic wr);
    int n = 0;
    @(negedge clk);
    while (!arb_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!arb_busy) begin
      checks++;
      fails++;
      $display("FAIL %s: no grant within 20 cycles", name);
    end else begin
      chk({name, " owner_d"}, arb_owner_d, exp_d);
      chk({name, " addr"}, pmem_address, addr);
      chk({name, " read"}, pmem_read, rd);
      chk({name, " write"}, pmem_write, wr);
    end
  endtask

  task automatic respond(input logic side_d, input lc3b_line data, input bit fwd);
    @(posedge clk); #1;
    pmem_resp  = 1'b1;
    pmem_rdata = data;
    if (fwd) sb.push_back('{side_d, data});
    @(posedge clk); #1;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    lc3b_line wd;
    rst_n          = 1'b0;
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h1234;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    pmem_rdata     = '0;
    pmem_resp      = 1'b0;

    // 1: reset with an I request pending
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst pmem_read", pmem_read, 0);
    chk("rst pmem_write", pmem_write, 0);
    chk("rst pmem_address", pmem_address, 0);
    chk("rst arb_busy", arb_busy, 0);
    chk("rst owner_d", arb_owner_d, 0);
    chk("rst i_resp", i_pmem_resp, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst idle read", pmem_read, 0);
    @(negedge clk);
    chk("post-rst grant read", pmem_read, 1);
    chk("post-rst grant addr", pmem_address, 16'h1230);
    chk("post-rst busy", arb_busy, 1);
    chk("post-rst owner_d", arb_owner_d, 0);

    // 2: the I read completes after 3 cycles
    repeat (2) @(posedge clk);
    respond(1'b0, {16{8'hA5}}, 1'b1);
    i_pmem_read = 1'b0;
    @(negedge clk);
    chk("t2 resp pulse ended", i_pmem_resp, 0);
    chk("t2 back idle", arb_busy, 0);

    // 3: simultaneous I and D, D first, I in the following IDLE slot
    @(posedge clk); #1;
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h2000;
    d_pmem_read    = 1'b1;
    d_pmem_address = 16'h3004;
    wait_grant("t3 d", 1'b1, 16'h3000, 1'b1, 1'b0);
    respond(1'b1, {4{32'h1357_9BDF}}, 1'b1);
    d_pmem_read = 1'b0;
    @(negedge clk);
    chk("t3 idle gap", arb_busy, 0);
    @(negedge clk);
    chk("t3 i busy", arb_busy, 1);
    chk("t3 i owner_d", arb_owner_d, 0);
    chk("t3 i addr", pmem_address, 16'h2000);
    respond(1'b0, {4{32'h2468_ACE0}}, 1'b1);
    i_pmem_read = 1'b0;

    // 4: D streak limited to 4 while I waits, then the streak restarts
    @(posedge clk); #1;
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h5557;
    d_pmem_read    = 1'b1;
    d_pmem_address = 16'h600C;
    for (int k = 0; k < 4; k++) begin
      wait_grant($sformatf("t4 d%0d", k), 1'b1, 16'h6000, 1'b1, 1'b0);
      respond(1'b1, {32{4'(k + 1)}}, 1'b1);
    end
    wait_grant("t4 i", 1'b0, 16'h5550, 1'b1, 1'b0);
    respond(1'b0, {16{8'h3C}}, 1'b1);
    wait_grant("t4 restart", 1'b1, 16'h6000, 1'b1, 1'b0);
    respond(1'b1, {16{8'hC3}}, 1'b1);
    i_pmem_read = 1'b0;
    d_pmem_read = 1'b0;

    // 5: D writeback, write wins over a simultaneous read, latched inputs
    wd = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    @(posedge clk); #1;
    d_pmem_write   = 1'b1;
    d_pmem_read    = 1'b1;
    d_pmem_address = 16'h4008;
    d_pmem_wdata   = wd;
    wait_grant("t5 wb", 1'b1, 16'h4000, 1'b0, 1'b1);
    chk("t5 wdata", pmem_wdata, wd);
    @(posedge clk); #1;
    d_pmem_address = 16'h7777;
    d_pmem_wdata   = '0;
    @(negedge clk);
    chk("t5 latched addr", pmem_address, 16'h4000);
    chk("t5 latched wdata", pmem_wdata, wd);
    respond(1'b1, {8{16'h0F0F}}, 1'b1);
    d_pmem_write = 1'b0;
    d_pmem_read  = 1'b0;

    // Owner drops its request: strobe held, completion discarded
    @(posedge clk); #1;
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h8888;
    wait_grant("drop i", 1'b0, 16'h8880, 1'b1, 1'b0);
    @(posedge clk); #1;
    i_pmem_read = 1'b0;
    @(negedge clk);
    chk("drop strobe held", pmem_read, 1);
    respond(1'b0, {16{8'h77}}, 1'b0);
    @(negedge clk);
    chk("drop back idle", arb_busy, 0);

    // Stray pmem_resp while idle
    respond(1'b0, {16{8'h99}}, 1'b0);
    @(negedge clk);
    chk("stray resp busy", arb_busy, 0);

    // 6: asynchronous reset in the middle of a D writeback
    @(posedge clk); #1;
    d_pmem_write   = 1'b1;
    d_pmem_address = 16'h9000;
    d_pmem_wdata   = wd;
    wait_grant("t6 wb", 1'b1, 16'h9000, 1'b0, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t6 async write", pmem_write, 0);
    chk("t6 async busy", arb_busy, 0);
    chk("t6 async wdata", pmem_wdata, 0);
    chk("t6 async owner_d", arb_owner_d, 0);
    d_pmem_write = 1'b0;
    @(posedge clk); #1;
    rst_n          = 1'b1;
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'hABCD;
    wait_grant("t6 after rst", 1'b0, 16'hABC0, 1'b1, 1'b0);
    respond(1'b0, {8{16'h5A5A}}, 1'b1);
    i_pmem_read = 1'b0;

    repeat (3) @(negedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single physical-memory port between the instruction cache and the data cache of the pipelined LC-3b.
- Data-side misses take priority, because a D-miss raises mem_stall and holds the execute-leapfrog path.
- A streak counter stops the I-side from being starved.
- Sits between both cache controllers and the pmem/L2 interface. One transaction is in flight at a time.

Parameters:
- LINE_W, 128, cache line width in bits.
- OFFSET_BITS, 4, low address bits forced to zero on pmem_address (line alignment).
- D_STREAK_MAX, 4, maximum consecutive D grants while an I request waits; range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_pmem_read  in  1  I-cache line read request
- i_pmem_address  in  16  I-cache request address
- i_pmem_rdata  out  LINE_W  line returned to I-cache
- i_pmem_resp  out  1  I-side completion pulse
- d_pmem_read  in  1  D-cache line read request
- d_pmem_write  in  1  D-cache line writeback request
- d_pmem_address  in  16  D-cache request address
- d_pmem_wdata  in  LINE_W  writeback data
- d_pmem_rdata  out  LINE_W  line returned to D-cache
- d_pmem_resp  out  1  D-side completion pulse
- pmem_read  out  1  downstream read strobe
- pmem_write  out  1  downstream write strobe
- pmem_address  out  16  downstream line address
- pmem_wdata  out  LINE_W  downstream write data
- pmem_rdata  in  LINE_W  downstream read data
- pmem_resp  in  1  downstream completion
- arb_busy  out  1  high while in SERVE_I or SERVE_D
- arb_owner_d  out  1  1 when the D-side owns or last owned the port

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- State machine: IDLE, SERVE_I, SERVE_D. Reset state is IDLE.
- Reset values: streak counter 0, arb_owner_d 0. All strobes, resps, arb_busy and pmem_address/wdata are 0.
- Requests are level-held by the caches until their resp. The arbiter samples them only in IDLE.

Grant decision in IDLE (registered, takes effect next cycle):
- Only D pending: go to SERVE_D.
- Only I pending: go to SERVE_I.
- Both pending and streak < D_STREAK_MAX: go to SERVE_D and increment the streak.
- Both pending and streak == D_STREAK_MAX: go to SERVE_I.
- On any I grant, or whenever i_pmem_read is low in IDLE, clear the streak.

Datapath during service:
- In SERVE_x, pmem_read/pmem_write/pmem_address/pmem_wdata are driven from the owner's inputs.
- pmem_address[OFFSET_BITS-1:0] is forced to 0.
- In SERVE_I, pmem_write is always 0 and pmem_wdata is 0.
- If d_pmem_read and d_pmem_write are both high, the write wins and pmem_read = 0.

Completion:
- On pmem_resp, the owner's resp is driven combinationally high for that cycle. The owner's rdata is pmem_rdata; the other side's rdata/resp stay 0.
- State returns to IDLE the next cycle.
- Minimum spacing: one IDLE cycle between transactions, so back-to-back grants are 2 cycles apart plus the pmem latency.

Latency:
- Request high at edge N (IDLE) gives pmem strobe high from N+1.
- Resp to the cache arrives in the same cycle as pmem_resp.

Boundary conditions:
- Owner drops its request before pmem_resp: the arbiter stays in SERVE until pmem_resp, keeps strobes asserted with latched address/kind, and discards the resp (resp not forwarded).
- Address and kind are latched at grant, so mid-transaction input changes are ignored.
- pmem_resp while IDLE: ignored.
- Reset mid-transaction: immediately IDLE and all outputs 0; pmem is expected to be reset together with the arbiter.

Decomposition:
- Add to lc3b_types:
  - lc3b_line typedef ([LINE_W-1:0]).
  - arb_state_t enum {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D}.
- One natural sub-module: pmem_arb_streak, a saturating streak counter with a clear input and an at_max flag.
- Everything else (FSM and output mux) stays in pmem_arbiter.

Test Plan:
1. Reset: hold rst_n=0 with i_pmem_read=1 -> all outputs 0 and state IDLE; release -> pmem_read=1 with pmem_address=I address & 0xFFF0 one cycle later.
2. Single I read at 0x1234, pmem_resp after 3 cycles with rdata=0xA5..A5 -> pmem_address=0x1230; i_pmem_resp is a 1-cycle pulse with matching rdata; d_pmem_resp stays 0.
3. I and D read requested in the same cycle -> D served first; I granted in the IDLE cycle after d_pmem_resp.
4. D keeps re-requesting with I pending and D_STREAK_MAX=4 -> exactly 4 D transactions, then 1 I transaction, then the streak restarts at 0.
5. D writeback 0x4008 with wdata=0xDEAD..BEEF -> pmem_write=1, pmem_read=0, address 0x4000, wdata passed unchanged; d_pmem_resp on pmem_resp.
6. rst_n pulsed low mid-SERVE_D -> pmem_write drops in the same cycle without a clock edge; after release, a new I request is granted normally.
